// File: rtl/fetch_ctrl.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and issues into IF/ID.
// Control transfers are followed by NOP shadow slots; DIV/DIVU holds fetch until the divider is ready.
module fetch_ctrl #(
  parameter int            AW          = 32,
  parameter logic [AW-1:0] RESET_PC    = '0,
  parameter int            FLUSH_SLOTS = 3,
  parameter int            DIV_CYCLES  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          muldiv_busy,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_incr,
  output logic [31:0]   instr,
  output logic          instr_valid
);

  typedef enum logic [1:0] {RUN, SHADOW, HOLD} state_e;

  localparam logic [3:0] FS = 4'(FLUSH_SLOTS);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_ctrl;
  logic       is_div;
  logic       issue;
  logic       advance;

  assign op      = imem_rdata[31:26];
  assign funct   = imem_rdata[5:0];
  assign is_ctrl = (op == 6'd2) || (op == 6'd3) || (op == 6'd4) || (op == 6'd5) ||
                   ((op == 6'd0) && (funct == 6'd8));
  assign is_div  = (op == 6'd0) && ((funct == 6'd26) || (funct == 6'd27));

  assign issue   = (state_q == RUN) && !rst && !stall && !redirect_valid;
  // A redirect lets SHADOW/HOLD progress even while the hazard unit stalls.
  assign advance = redirect_valid || !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_incr;
    end

    if (advance) begin
      unique case (state_q)
        RUN: begin
          if (issue && is_ctrl && (FS != 4'd0)) begin
            state_d = SHADOW;
            cnt_d   = 4'd1;
          end else if (issue && is_div) begin
            state_d = HOLD;
            cnt_d   = 4'd1;
          end
        end
        SHADOW: begin
          if (cnt_q == FS) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HOLD: begin
          if ((cnt_q >= DC) && !muldiv_busy) begin
            state_d = RUN;
          end else if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_incr     = pc_q + AW'(4);
  assign instr_valid = issue;
  assign instr       = issue ? imem_rdata : 32'h0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two configurations share one stimulus stream; a per-instance reference
// model queues the expected outputs and a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, rv = 1'b0, busy = 1'b0;
  logic [31:0] rpc = 32'h0, rdata = 32'h0;

  logic [31:0] addr0, pc0, pci0, ins0;
  logic        v0;
  logic [31:0] addr1, pc1, pci1, ins1;
  logic        v1;

  fetch_ctrl #(.AW(32), .RESET_PC(32'h0), .FLUSH_SLOTS(3), .DIV_CYCLES(5)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .muldiv_busy(busy), .imem_addr(addr0), .imem_rdata(rdata), .pc(pc0),
    .pc_incr(pci0), .instr(ins0), .instr_valid(v0)
  );

  fetch_ctrl #(.AW(32), .RESET_PC(32'hFFFF_FFF4), .FLUSH_SLOTS(0), .DIV_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .muldiv_busy(busy), .imem_addr(addr1), .imem_rdata(rdata), .pc(pc1),
    .pc_incr(pci1), .instr(ins1), .instr_valid(v1)
  );

  typedef struct packed {
    logic        pck;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pci;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  // Reference model: slots still to skip, and whether a divide is pending with its elapsed count.
  int          fs_cfg[2]  = '{3, 0};
  int          dc_cfg[2]  = '{5, 2};
  logic [31:0] rst_pc[2]  = '{32'h0, 32'hFFFF_FFF4};
  logic [31:0] mpc[2];
  bit          known[2]   = '{1'b0, 1'b0};
  int          shadow_left[2] = '{0, 0};
  bit          in_div[2]  = '{1'b0, 1'b0};
  int          elapsed[2] = '{0, 0};

  localparam int K_ADD = 0, K_J = 1, K_JAL = 2, K_BEQ = 3, K_BNE = 4, K_JR = 5,
                 K_DIV = 6, K_DIVU = 7, K_ADDI = 8;

  function automatic logic [31:0] mk(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_J:     return {6'd2, r[25:0]};
      K_JAL:   return {6'd3, r[25:0]};
      K_BEQ:   return {6'd4, r[25:0]};
      K_BNE:   return {6'd5, r[25:0]};
      K_JR:    return {6'd0, r[25:6], 6'd8};
      K_DIV:   return {6'd0, r[25:6], 6'd26};
      K_DIVU:  return {6'd0, r[25:6], 6'd27};
      K_ADDI:  return {6'd8, r[25:0]};
      default: return {6'd0, r[25:6], 6'd32};
    endcase
  endfunction

  function automatic bit ref_ctrl(input logic [31:0] w);
    return (w[31:26] inside {6'd2, 6'd3, 6'd4, 6'd5}) || (w[31:26] == 6'd0 && w[5:0] == 6'd8);
  endfunction

  function automatic bit ref_div(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] inside {6'd26, 6'd27});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue each instance's expected outputs, then advance the model.
  task automatic drive(input bit r, input bit s, input bit v, input logic [31:0] tgt,
                       input bit b, input logic [31:0] w);
    @(posedge clk);
    #1;
    rst = r; stall = s; rv = v; rpc = tgt; busy = b; rdata = w;
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   issued;
      issued = !r && !s && !v && (shadow_left[k] == 0) && !in_div[k];
      e.pck = known[k];
      e.v   = issued;
      e.ins = issued ? w : 32'h0;
      e.pc  = mpc[k];
      e.pci = mpc[k] + 32'd4;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      if (r) begin
        mpc[k] = rst_pc[k]; known[k] = 1'b1;
        shadow_left[k] = 0; in_div[k] = 1'b0; elapsed[k] = 0;
      end else begin
        if (v) mpc[k] = tgt;
        else if (issued) mpc[k] = mpc[k] + 32'd4;
        if (v || !s) begin
          if (shadow_left[k] > 0) shadow_left[k]--;
          else if (in_div[k]) begin
            if (elapsed[k] >= dc_cfg[k] && !b) in_div[k] = 1'b0;
            else elapsed[k]++;
          end
        end
        if (issued && ref_ctrl(w) && fs_cfg[k] > 0) shadow_left[k] = fs_cfg[k];
        if (issued && ref_div(w)) begin
          in_div[k] = 1'b1; elapsed[k] = 1;
        end
      end
    end
  endtask

  task automatic run(input int kind);
    drive(0, 0, 0, 32'h0, 0, mk(kind));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("i0.instr_valid", {31'h0, v0}, {31'h0, e.v});
      chk("i0.instr", ins0, e.ins);
      if (e.pck) begin
        chk("i0.pc", pc0, e.pc);
        chk("i0.pc_incr", pci0, e.pci);
        chk("i0.imem_addr", addr0, e.pc);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("i1.instr_valid", {31'h0, v1}, {31'h0, e.v});
      chk("i1.instr", ins1, e.ins);
      if (e.pck) begin
        chk("i1.pc", pc1, e.pc);
        chk("i1.pc_incr", pci1, e.pci);
        chk("i1.imem_addr", addr1, e.pc);
      end
    end
  end

  initial begin
    // Reset, straight-line, jump with a redirect inside the shadow
    drive(1, 0, 0, 32'h0, 0, mk(K_ADD));
    drive(1, 0, 0, 32'h0, 0, mk(K_J));
    repeat (4) run(K_ADD);
    run(K_J);
    run(K_ADD);
    drive(0, 0, 1, 32'h40, 0, mk(K_ADD));
    repeat (3) run(K_ADD);
    run(K_J);
    repeat (5) run(K_ADD);
    // DIVU with busy, then without
    run(K_DIVU);
    repeat (6) drive(0, 0, 0, 32'h0, 1, mk(K_ADD));
    repeat (3) run(K_ADD);
    run(K_DIVU);
    repeat (7) run(K_ADD);
    // Stall in RUN and mid-shadow
    repeat (3) drive(0, 1, 0, 32'h0, 0, mk(K_ADD));
    run(K_BNE);
    run(K_ADD);
    repeat (3) drive(0, 1, 0, 32'h0, 0, mk(K_ADD));
    repeat (4) run(K_ADD);
    // Redirect squashes a branch, with and without stall
    drive(0, 0, 1, 32'h100, 0, mk(K_BEQ));
    repeat (2) run(K_ADD);
    drive(0, 1, 1, 32'h100, 0, mk(K_BEQ));
    repeat (2) run(K_ADD);
    // Reset on the second hold cycle
    run(K_DIV);
    run(K_ADD);
    drive(1, 0, 0, 32'h0, 1, mk(K_ADD));
    repeat (4) run(K_JR);
    // Long divide exercising counter saturation
    run(K_DIV);
    repeat (20) drive(0, 0, 0, 32'h0, 1, mk(K_ADD));
    repeat (3) run(K_ADD);
    // PC wrap at the top of the address space
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, mk(K_ADD));
    repeat (3) run(K_ADD);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v, b;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 2) != 0);
      drive(r, s, v, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, b, mk($urandom_range(0, 8)));
    end
    repeat (2) @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
